// File: rtl/mem_access_unit.sv
// RV32I memory-access stage: byte/half/word loads with extension, and stores
// with sub-word read-modify-write. Optional `MISALIGN_TRAP_EN faults misaligned accesses.
module mem_access_unit #(
    parameter int MEM_BYTES = 64
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        fault
);

    typedef enum logic {IDLE, RMW_WR} state_t;

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    state_t      state_q, state_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        fault_q, fault_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rmw_addr_q, rmw_addr_d;

    logic        accept;
    logic        f3_ok_load;
    logic        f3_ok_store;
    logic [32:0] size;
    logic        range_bad;
    logic        misalign;
    logic        bad;
    logic [31:0] load_ext;

    assign req_ready  = (state_q == IDLE);
    assign stall      = ~req_ready;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign fault      = fault_q;

    always_comb begin
        // Gating with Rst keeps the memory quiet while reset is held low.
        accept      = req_valid && (state_q == IDLE) && Rst;
        f3_ok_load  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b101);
        f3_ok_store = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);

        case (funct3[1:0])
            2'b00:   size = 33'd1;
            2'b01:   size = 33'd2;
            default: size = 33'd4;
        endcase
        range_bad = ({1'b0, addr} + size) > MEM_LIMIT;

`ifdef MISALIGN_TRAP_EN
        misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif

        bad = (is_load && is_store) ||
              (is_load && !f3_ok_load) ||
              (is_store && !f3_ok_store) ||
              ((is_load || is_store) && (range_bad || misalign));

        case (funct3)
            3'b000:  load_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            3'b001:  load_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            3'b100:  load_ext = {24'd0, mem_rdata[7:0]};
            3'b101:  load_ext = {16'd0, mem_rdata[15:0]};
            default: load_ext = mem_rdata;
        endcase

        state_d      = state_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        fault_d      = 1'b0;
        merge_d      = merge_q;
        rmw_addr_d   = rmw_addr_q;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bad) begin
                        fault_d = 1'b1;
                    end else if (is_load) begin
                        mem_addr     = addr;
                        mem_read     = 1'b1;
                        load_data_d  = load_ext;
                        load_valid_d = 1'b1;
                    end else if (is_store) begin
                        mem_addr = addr;
                        if (funct3 == 3'b010) begin
                            mem_wdata = wdata;
                            mem_write = 1'b1;
                        end else begin
                            mem_read   = 1'b1;
                            rmw_addr_d = addr;
                            merge_d    = funct3[0] ? {mem_rdata[31:16], wdata[15:0]}
                                                   : {mem_rdata[31:8], wdata[7:0]};
                            state_d    = RMW_WR;
                        end
                    end
                end
            end
            RMW_WR: begin
                if (Rst) begin
                    mem_addr  = rmw_addr_q;
                    mem_wdata = merge_q;
                    mem_write = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q      <= IDLE;
            load_data_q  <= 32'd0;
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            merge_q      <= 32'd0;
            rmw_addr_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            fault_q      <= fault_d;
            merge_q      <= merge_d;
            rmw_addr_q   <= rmw_addr_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven bench for mem_access_unit with a byte-array memory model and
// a scoreboard queue of expected registered results.
module tb_mem_access_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        req_valid;
    logic        req_ready;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        fault;

    mem_access_unit #(.MEM_BYTES(64)) dut (
        .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_ready(req_ready),
        .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
        .wdata(wdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid), .fault(fault)
    );

    always #5 Clk = ~Clk;

    logic [7:0] tb_mem [0:63];
    logic       preload;

    function automatic logic [7:0] preset(input int i);
        case (i)
            16'h10: return 8'h84;
            16'h11: return 8'h83;
            16'h12: return 8'h82;
            16'h13: return 8'h81;
            16'h14: return 8'h95;
            16'h20: return 8'h44;
            16'h21: return 8'h33;
            16'h22: return 8'h22;
            16'h23: return 8'h11;
            16'h3F: return 8'h80;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge Clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= preset(i);
        end else if (mem_write) begin
            for (int i = 0; i < 4; i++)
                if (({1'b0, mem_addr} + 33'(i)) < 33'd64)
                    tb_mem[6'(mem_addr[5:0] + 6'(i))] <= mem_wdata[8*i +: 8];
        end
    end

    always_comb begin
        mem_rdata = 32'd0;
        for (int i = 0; i < 4; i++)
            if (({1'b0, mem_addr} + 33'(i)) < 33'd64)
                mem_rdata[8*i +: 8] = tb_mem[6'(mem_addr[5:0] + 6'(i))];
    end

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic        exp_lv;
        logic        exp_flt;
        logic [31:0] exp_data;
        logic        exp_rd;
        logic        exp_wr;
        logic        rmw;
        logic [31:0] exp_word;
    } vec_t;

    typedef struct {
        logic        lv;
        logic        flt;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[20];
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] exp_last = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   k;
        exp_t e;
        k = 0;
        @(negedge Clk);
        while (!req_ready && k < 20) begin
            @(negedge Clk);
            k++;
        end
        if (k >= 20) chk($sformatf("v%0d_ready_timeout", idx), 32'd0, 32'd1);
        req_valid = 1'b1;
        is_load   = v.ld;
        is_store  = v.st;
        funct3    = v.f3;
        addr      = v.a;
        wdata     = v.wd;
        #1;
        chk($sformatf("v%0d_mem_read", idx), 32'(mem_read), 32'(v.exp_rd));
        chk($sformatf("v%0d_mem_write", idx), 32'(mem_write), 32'(v.exp_wr));
        if (v.exp_rd || v.exp_wr) chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.a);
        if (v.exp_wr) chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.wd);
        $display("vec %0d: ld=%0b st=%0b f3=%b addr=%h wdata=%h", idx, v.ld, v.st, v.f3, v.a, v.wd);
        sb.push_back('{v.exp_lv, v.exp_flt, v.exp_lv ? v.exp_data : exp_last});
        if (v.exp_lv) exp_last = v.exp_data;
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        e = sb.pop_front();
        chk($sformatf("v%0d_load_valid", idx), 32'(load_valid), 32'(e.lv));
        chk($sformatf("v%0d_fault", idx), 32'(fault), 32'(e.flt));
        chk($sformatf("v%0d_load_data", idx), load_data, e.data);
        chk($sformatf("v%0d_stall", idx), 32'(stall), 32'(v.rmw));
        if (v.rmw) begin
            chk($sformatf("v%0d_rmw_write", idx), 32'(mem_write), 32'd1);
            chk($sformatf("v%0d_rmw_read", idx), 32'(mem_read), 32'd0);
            chk($sformatf("v%0d_rmw_addr", idx), mem_addr, v.a);
            chk($sformatf("v%0d_rmw_word", idx), mem_wdata, v.exp_word);
        end
        @(posedge Clk);
        #1;
        chk($sformatf("v%0d_lv_clear", idx), 32'(load_valid), 32'd0);
        chk($sformatf("v%0d_fault_clear", idx), 32'(fault), 32'd0);
        chk($sformatf("v%0d_ready_back", idx), 32'(req_ready), 32'd1);
        chk($sformatf("v%0d_idle_write", idx), 32'(mem_write), 32'd0);
    endtask

    initial begin
        vec_t lw20;
        //          ld    st    f3      addr          wdata         lv    flt   data          rd    wr    rmw   word
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h10,       32'h0,        1'b1, 1'b0, 32'hFFFFFF84, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 3'b100, 32'h10,       32'h0,        1'b1, 1'b0, 32'h00000084, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 3'b010, 32'h10,       32'h0,        1'b1, 1'b0, 32'h81828384, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h10,       32'h0,        1'b1, 1'b0, 32'hFFFF8384, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h12,       32'h0,        1'b1, 1'b0, 32'h00008182, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 3'b000, 32'h10,       32'hAABBCCDD, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h818283DD};
        vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h10,       32'h0,        1'b1, 1'b0, 32'h818283DD, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 3'b001, 32'h20,       32'h0000BEEF, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h1122BEEF};
        vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h20,       32'h0,        1'b1, 1'b0, 32'h1122BEEF, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h3E,       32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 3'b011, 32'h0,        32'h12345678, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 3'b011, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b1, 3'b010, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 1'b1, 3'b010, 32'h30,       32'h12345678, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 3'b010, 32'h30,       32'h0,        1'b1, 1'b0, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 1'b0, 3'b000, 32'h3F,       32'h0,        1'b1, 1'b0, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[16] = '{1'b1, 1'b0, 3'b001, 32'h3F,       32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
        vecs[17] = '{1'b1, 1'b0, 3'b010, 32'h3C,       32'h0,        1'b1, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[18] = '{1'b1, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
`ifdef MISALIGN_TRAP_EN
        vecs[19] = '{1'b1, 1'b0, 3'b010, 32'h11,       32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
`else
        vecs[19] = '{1'b1, 1'b0, 3'b010, 32'h11,       32'h0,        1'b1, 1'b0, 32'h95818283, 1'b1, 1'b0, 1'b0, 32'h0};
`endif
        lw20 = vecs[8];

        Rst = 1'b0; preload = 1'b1; req_valid = 1'b0;
        is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        preload = 1'b0;
        Rst = 1'b1;
        #1;
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_load_valid", 32'(load_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);

        for (int i = 0; i < 20; i++) run_vec(vecs[i], i);

        // Reset landing in the write cycle of an SB must cancel the write.
        @(negedge Clk);
        req_valid = 1'b1; is_load = 1'b0; is_store = 1'b1;
        funct3 = 3'b000; addr = 32'h20; wdata = 32'h00000077;
        @(posedge Clk);
        #1;
        req_valid = 1'b0; is_store = 1'b0;
        chk("abort_stall", 32'(stall), 32'd1);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        chk("abort_no_write", 32'(mem_write), 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        $display("abort: reset during RMW_WR, ready=%0b", req_ready);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_load_data", load_data, 32'd0);
        chk("abort_mem_byte", 32'(tb_mem[32]), 32'h000000EF);
        exp_last = 32'd0;
        run_vec(lw20, 20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage of the RV32I pipeline, between the EX/MEM pipeline register and the byte-addressed 64-byte data memory. Turns RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into full-word memory transactions. Sub-word stores use a two-cycle read-modify-write sequence, which stalls the pipeline. Loads are byte-selected, sign- or zero-extended, and registered for the MEM/WB stage.

## Interface
- MEM_BYTES, 64, data memory size in bytes; accesses reaching past it fault.
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- is_load  in  1  request is a load.
- is_store  in  1  request is a store.
- funct3  in  3  RV32I width/sign code.
- addr  in  32  byte address.
- wdata  in  32  store data (rs2); only low byte/half used for SB/SH.
- mem_addr  out  32  address to data memory.
- mem_wdata  out  32  full word to data memory.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_rdata  in  32  little-endian word read combinationally at mem_addr.
- stall  out  1  freeze upstream stages; equals ~req_ready.
- load_data  out  32  registered, extended load result.
- load_valid  out  1  one-cycle pulse: load_data valid.
- fault  out  1  one-cycle pulse: request rejected, no memory write performed.

## Operation
- States: IDLE, RMW_WR.
- A request is accepted when req_valid && req_ready.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Fault conditions; on any of these, fault pulses and mem_read/mem_write stay 0:
  - illegal funct3;
  - is_load && is_store;
  - addr + size − 1 ≥ MEM_BYTES, where size is 1/2/4.
- Loads, in IDLE:
  - Drive mem_addr=addr and mem_read=1.
  - Capture mem_rdata: byte [7:0], half [15:0], or full word.
  - Sign-extend (LB/LH) or zero-extend (LBU/LHU) to 32 bits, then register into load_data.
- SW, in IDLE: mem_addr=addr, mem_wdata=wdata, mem_write=1, single cycle.
- SB/SH, cycle 1 (IDLE):
  - Drive mem_addr=addr and mem_read=1.
  - Latch addr, funct3 and wdata, plus merged word = {mem_rdata[31:8], wdata[7:0]} (SB) or {mem_rdata[31:16], wdata[15:0]} (SH).
  - Go to RMW_WR.
- SB/SH, cycle 2 (RMW_WR): mem_addr=latched addr, mem_wdata=merged word, mem_write=1; return to IDLE.
- mem_read and mem_write are never high in the same cycle.
- Outside an active access: mem_addr=0, mem_wdata=0, mem_read=0, mem_write=0.
- Address arithmetic is 32-bit unsigned; the range check must not wrap (use a 33-bit sum).

## Timing
- Reset (Rst=0 at an edge):
  - state=IDLE, load_data=0, load_valid=0, fault=0, merge register=0.
  - mem_read=0, mem_write=0 in the following cycle.
- Load accepted in cycle N → load_data valid and load_valid=1 in N+1 for exactly one cycle; no stall.
- SW accepted in N → written in N; req_ready stays 1.
- SB/SH accepted in N → mem_read in N; mem_write in N+1 with req_ready=0 and stall=1; req_ready=1 again in N+2.
- Fault detected in N → fault=1 in N+1 for one cycle; load_valid=0; state stays IDLE.
- req_valid in RMW_WR is ignored; the requester must hold it until req_ready.
- Reset asserted during RMW_WR aborts the write: no mem_write after that edge.
- load_data holds its value until the next accepted load.

## Configuration
- MISALIGN_TRAP_EN:
  - Defined: LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0, fault and perform no memory access.
  - Undefined: misaligned accesses are performed at the byte address given (memory is byte-addressed) and do not fault.
  - The range check applies in both cases.

## Test plan
- Reset, then memory bytes 0x10..0x13 = 84 83 82 81; LB at 0x10 → load_data=0xFFFFFF84; LBU → 0x00000084; LW → 0x81828384; load_valid one cycle each.
- SB wdata=0xAABBCCDD at 0x10 over word 0x81828384 → mem_read in N; mem_write in N+1 with mem_wdata=0x818283DD; stall=1 in N+1 only.
- SH wdata=0x0000BEEF at 0x20 over 0x11223344 → write 0x1122BEEF; a back-to-back LW at 0x20 is accepted in N+2 → 0x1122BEEF.
- LW at 0x3E with MEM_BYTES=64 → fault in the next cycle, mem_read=0; funct3=011 store → fault, no mem_write.
- With MISALIGN_TRAP_EN: LW at 0x11 → fault. Without it: LW at 0x11 → 0x??818283, where the top byte is memory byte 0x14.
- Rst low in the RMW_WR cycle of an SB → mem_write=0, memory unchanged, req_ready=1 after reset is released.
